// File: rtl/ex_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit_pkg
// Shared definitions for the RV64M multiply/divide unit:
//   - funct3 operation encodings (OP_MUL .. OP_REMU)
//   - FSM state type (ST_IDLE, ST_CALC, ST_FIX, ST_DONE)
//   - is_div(): funct3 bit 2 separates the divide family from multiplies
// ---------------------------------------------------------------------------
package ex_muldiv_unit_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_operand_prep.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit_operand_prep
// Combinational operand preparation for the multiply/divide unit. Decides the
// signedness of each operand from funct3, produces operand magnitudes and the
// sign corrections to apply after the unsigned core has finished.
// Ports:
//   op_i        funct3 of the M-extension op
//   a_i, b_i    rs1 / rs2 operands
//   a_mag_o     |a| (a itself when a is treated as unsigned)
//   b_mag_o     |b| (b itself when b is treated as unsigned)
//   neg_res_o   product / quotient must be negated (operand signs differ)
//   neg_rem_o   remainder must be negated (dividend negative)
//   div_zero_o  divide-family op with b == 0
//   div_ovf_o   signed DIV/REM of the most negative value by -1
// ---------------------------------------------------------------------------
module ex_muldiv_unit_operand_prep
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] a_mag_o,
    output logic [XLEN-1:0] b_mag_o,
    output logic            neg_res_o,
    output logic            neg_rem_o,
    output logic            div_zero_o,
    output logic            div_ovf_o
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic a_signed;
    logic b_signed;
    logic a_neg;
    logic b_neg;

    // MUL takes the signed path too: the low half is identical either way.
    assign a_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                      (op_i == OP_DIV) || (op_i == OP_REM);
    assign b_signed = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                      (op_i == OP_DIV) || (op_i == OP_REM);

    assign a_neg = a_signed & a_i[XLEN-1];
    assign b_neg = b_signed & b_i[XLEN-1];

    // Negating the most negative value wraps back onto itself, which is
    // exactly its magnitude when read as unsigned.
    assign a_mag_o = a_neg ? -a_i : a_i;
    assign b_mag_o = b_neg ? -b_i : b_i;

    assign neg_res_o  = a_neg ^ b_neg;
    assign neg_rem_o  = a_neg;
    assign div_zero_o = is_div(op_i) && (b_i == '0);
    assign div_ovf_o  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                        (a_i == MOST_NEG) && (b_i == '1);

endmodule

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV64M multiply/divide unit for the EX stage. Accepts an op from
// ID/EX, holds busy while it iterates one radix-2 step per cycle, then pulses
// done for one cycle with the result and destination register.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   start         ID/EX holds a valid M-op (only honoured while idle)
//   op            funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b          rs1 / rs2 operands
//   rd_in         destination register index
//   flush         squash the in-flight op; returns to idle without done
//   busy          unit occupied (front-end stall)
//   done          one-cycle completion pulse
//   result        completed result, held until the next completion
//   rd_out        destination of the completed op
// Configuration:
//   MULDIV_EARLY_OUT_EN  multiply leaves CALC once the remaining multiplier
//                        bits are zero; divide with |a| < |b| skips CALC.
//                        Undefined: every non-div-by-zero op takes XLEN
//                        CALC cycles.
// ---------------------------------------------------------------------------
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [RD_W-1:0] rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Sign fix-up helpers applied in FIX.
    function automatic logic [2*XLEN-1:0] sign_fix_wide(input logic [2*XLEN-1:0] v,
                                                        input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                ovf_q, ovf_d;
    // acc: product accumulator (mul) or partial remainder in the low half (div).
    // mcand: multiplicand shifted left each step (mul) or divisor (div).
    // shreg: multiplier shifted right (mul) or dividend in / quotient out (div).
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     shreg_q, shreg_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [RD_W-1:0]     rd_out_q, rd_out_d;

    logic [XLEN-1:0]     a_mag, b_mag;
    logic                neg_res, neg_rem, div_zero, div_ovf;

    logic [2*XLEN-1:0]   mul_acc;
    logic [XLEN-1:0]     mul_shreg;
    logic [XLEN:0]       rem_sh, rem_diff;
    logic [XLEN-1:0]     div_rem, div_quo;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s, rem_s;

    ex_muldiv_unit_operand_prep #(.XLEN(XLEN)) u_prep (
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .a_mag_o    (a_mag),
        .b_mag_o    (b_mag),
        .neg_res_o  (neg_res),
        .neg_rem_o  (neg_rem),
        .div_zero_o (div_zero),
        .div_ovf_o  (div_ovf)
    );

    // Shift-add multiply step: multiplicand moves left, multiplier right, so
    // the accumulator is always in final alignment.
    assign mul_acc   = shreg_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_shreg = shreg_q >> 1;

    // Restoring divide step: bring in the next dividend bit, try to subtract.
    assign rem_sh   = {acc_q[XLEN-1:0], shreg_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
    assign div_rem  = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
    assign div_quo  = {shreg_q[XLEN-2:0], ~rem_diff[XLEN]};

    assign prod_s = sign_fix_wide(acc_q, neg_res_q);
    assign quo_s  = sign_fix(shreg_q, neg_res_q);
    assign rem_s  = sign_fix(acc_q[XLEN-1:0], neg_rem_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        ovf_d     = ovf_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        shreg_d   = shreg_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d      = op;
                    rd_d      = rd_in;
                    neg_res_d = neg_res;
                    neg_rem_d = neg_rem;
                    ovf_d     = div_ovf;
                    cnt_d     = CNT_LAST;
                    acc_d     = '0;
                    if (is_div(op)) begin
                        mcand_d = {{XLEN{1'b0}}, b_mag};
                        shreg_d = a_mag;
                    end else begin
                        mcand_d = {{XLEN{1'b0}}, a_mag};
                        shreg_d = b_mag;
                    end
                    if (div_zero) begin
                        // Quotient all ones, remainder is the dividend unchanged.
                        state_d  = ST_DONE;
                        result_d = op[1] ? a : '1;
                        rd_out_d = rd_in;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if (is_div(op) && (a_mag < b_mag)) begin
                        state_d = ST_FIX;
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        shreg_d = '0;
                    end
`endif
                    else begin
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div(op_q)) begin
                    acc_d   = {{XLEN{1'b0}}, div_rem};
                    shreg_d = div_quo;
                end else begin
                    acc_d   = mul_acc;
                    mcand_d = mcand_q << 1;
                    shreg_d = mul_shreg;
                end
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
`ifdef MULDIV_EARLY_OUT_EN
                if (!is_div(op_q) && (mul_shreg == '0)) begin
                    state_d = ST_FIX;
                end
`endif
            end

            ST_FIX: begin
                case (op_q)
                    OP_MUL:                      result_d = prod_s[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_s[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:             result_d = ovf_q ? MOST_NEG : quo_s;
                    OP_REM, OP_REMU:             result_d = ovf_q ? '0 : rem_s;
                    default:                     result_d = result_q;
                endcase
                rd_out_d = rd_q;
                state_d  = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A squash wins over everything, including a completion in FIX.
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            shreg_q   <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            ovf_q     <= ovf_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            shreg_q   <= shreg_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE) && !flush;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Scoreboard bench for ex_muldiv_unit: the stimulus process pushes expected
// completions into a queue, the monitor pops and compares on every done.
// Directed vectors carry literal expected values; random vectors use a
// reference model built on wide-integer arithmetic.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    localparam int XLEN = 64;
    localparam int RD_W = 5;
    localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      op = 3'd0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic [RD_W-1:0] rd_in = '0;
    logic            flush = 1'b0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd_out;

    ex_muldiv_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .rd_in   (rd_in),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          acc;
        int          lat;
        int          bcnt;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          busy_run = 0;
    logic [63:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    // Output-state check requests from the stimulus process.
    int          req_id = 0;
    int          seen_id = 0;
    string       req_name = "";
    bit          req_empty = 1'b0;
    logic        req_busy = 1'b0;
    logic        req_done = 1'b0;
    logic [63:0] req_res = '0;
    logic [4:0]  req_rd = '0;

    // Reference model: plain wide-integer arithmetic with the RV64M rules.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] x,
                                          input logic [63:0] y);
        logic signed [127:0] sx, sy, p;
        longint qx, qy;
        bit ovf;
        sx  = (o == 3'd0 || o == 3'd1 || o == 3'd2) ? {{64{x[63]}}, x} : {64'd0, x};
        sy  = (o == 3'd0 || o == 3'd1) ? {{64{y[63]}}, y} : {64'd0, y};
        p   = sx * sy;
        qx  = x;
        qy  = y;
        ovf = (x == MOST_NEG) && (y == ONES);
        case (o)
            3'd0: return p[63:0];
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4: return (y == 0) ? ONES : (ovf ? MOST_NEG : 64'(qx / qy));
            3'd5: return (y == 0) ? ONES : x / y;
            3'd6: return (y == 0) ? x : (ovf ? 64'd0 : 64'(qx % qy));
            3'd7: return (y == 0) ? x : x % y;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = ONES;
            2: v = MOST_NEG;
            3: v = 64'd1;
            4: v = 64'($urandom_range(0, 20));
            5: v = {$urandom, $urandom} >> $urandom_range(0, 63);
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        busy_run = busy ? busy_run + 1 : 0;
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {59'd0, rd_out}, 64'hFFFF);
            end else begin
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("rd_out", {59'd0, rd_out}, {59'd0, e.rd});
                chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                chk("busy_cycles", 64'(busy_run), 64'(e.bcnt));
            end
        end
        if (req_id != seen_id) begin
            seen_id = req_id;
            if (req_empty) begin
                chk(req_name, 64'(sb_q.size()), 64'd0);
            end else begin
                chk({req_name, ".busy"}, {63'd0, busy}, {63'd0, req_busy});
                chk({req_name, ".done"}, {63'd0, done}, {63'd0, req_done});
                chk({req_name, ".result"}, result, req_res);
                chk({req_name, ".rd_out"}, {59'd0, rd_out}, {59'd0, req_rd});
            end
        end
    end

    task automatic req_check(input string nm, input logic bz, input logic dn,
                             input logic [63:0] r, input logic [4:0] d, input bit empty);
        req_name  = nm;
        req_busy  = bz;
        req_done  = dn;
        req_res   = r;
        req_rd    = d;
        req_empty = empty;
        req_id++;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy) begin
            if (t > 300) begin
                $display("FAIL idle_timeout: busy still high after %0d cycles", t);
                $fatal(1, "unit never returned to idle");
            end
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [4:0] r, input logic [63:0] er, input bit track);
        exp_t e;
        bit   dz;
        wait_idle();
        op    = o;
        a     = x;
        b     = y;
        rd_in = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            dz     = o[2] && (y == 0);
            e.res  = er;
            e.rd   = r;
            e.acc  = cyc;
            e.lat  = dz ? 0 : XLEN + 1;
            e.bcnt = dz ? 1 : XLEN + 2;
            sb_q.push_back(e);
            last_res = er;
            last_rd  = r;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  ro;
        logic [63:0] rx, ry;

        repeat (2) @(posedge clk);
        #1;
        req_check("reset_state", 1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with literal expectations.
        issue(3'd0, 64'd7, -64'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        issue(3'd3, ONES, ONES, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        issue(3'd1, ONES, ONES, 5'd7, 64'd0, 1'b1);
        issue(3'd2, ONES, ONES, 5'd8, ONES, 1'b1);
        issue(3'd4, -64'd7, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        issue(3'd6, -64'd7, 64'd2, 5'd10, ONES, 1'b1);
        issue(3'd5, 64'd7, 64'd0, 5'd11, ONES, 1'b1);
        issue(3'd6, 64'd7, 64'd0, 5'd12, 64'd7, 1'b1);
        issue(3'd4, MOST_NEG, ONES, 5'd13, MOST_NEG, 1'b1);
        issue(3'd6, MOST_NEG, ONES, 5'd14, 64'd0, 1'b1);

        // Start pulses while busy must be ignored.
        issue(3'd7, 64'd100, 64'd7, 5'd15, 64'd2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        op    = 3'd5;
        b     = 64'd0;
        rd_in = 5'd31;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;

        // Flush during CALC: no completion, outputs hold.
        issue(3'd0, 64'd123, 64'd456, 5'd20, 64'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_check("flush_calc", 1'b0, 1'b0, last_res, last_rd, 1'b0);

        // Flush and start together while idle: nothing accepted.
        op    = 3'd5;
        b     = 64'd0;
        rd_in = 5'd21;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        req_check("flush_start_idle", 1'b0, 1'b0, last_res, last_rd, 1'b0);

        // Asynchronous reset in the middle of CALC.
        issue(3'd4, 64'd1000, 64'd3, 5'd22, 64'd0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        reset_n = 1'b0;
        last_res = '0;
        last_rd  = '0;
        req_check("mid_reset", 1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue(3'd0, 64'd9, 64'd9, 5'd23, 64'd81, 1'b1);

        // Randomised ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = pick();
            ry = pick();
            issue(ro, rx, ry, 5'($urandom_range(1, 31)), model(ro, rx, ry), 1'b1);
        end

        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        req_check("scoreboard_empty", 1'b0, 1'b0, 64'd0, 5'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
